// File: rtl/kws_relu_wb_slave_if.sv
// Wishbone-B4 classic slave bus bundle for the KWS ReLU engine.
interface kws_relu_wb_slave_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );
  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/kws_relu_wb_slave.sv
// Wishbone slave wrapping a single-value ReLU engine: write DATA_IN, start via CTRL,
// read DATA_OUT = max(operand, 0).
module kws_relu_wb_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          DATA_W    = 32,
  parameter logic [3:0]  RELU_OP   = 4'h5
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_n,
  kws_relu_wb_slave_if.slave wbs
);
  typedef enum logic {IDLE, EXEC} state_t;

  state_t            state;
  logic [1:0]        rst_sync;
  logic              rst_n_i;
  logic [3:0]        opcode;
  logic [DATA_W-1:0] data_in, data_out;
  logic              busy, done, err;
  logic              hit, req, wr, ctrl_wr;
  logic [5:0]        widx;
  logic [31:0]       rdata;
  logic              unused_adr;

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n)
    if (!wb_rst_n) rst_sync <= '0;
    else           rst_sync <= {rst_sync[0], 1'b1};
  assign rst_n_i = rst_sync[1];

  assign hit        = wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8];
  assign req        = wbs.wbs_stb_i & wbs.wbs_cyc_i & hit & ~wbs.wbs_ack_o;
  assign wr         = req & wbs.wbs_we_i;
  assign widx       = wbs.wbs_adr_i[7:2];
  assign ctrl_wr    = wr && widx == 6'd0 && wbs.wbs_sel_i[0];
  assign unused_adr = ^wbs.wbs_adr_i[1:0];

  always_comb begin
    rdata = '0;
    case (widx)
      6'd0:    rdata[3:0] = opcode;
      6'd1:    rdata = data_in;
      6'd2:    rdata = data_out;
      6'd3:    rdata = {29'd0, err, done, busy};
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      wbs.wbs_ack_o <= 1'b0;
      wbs.wbs_dat_o <= '0;
    end else begin
      wbs.wbs_ack_o <= req;
      wbs.wbs_dat_o <= (req && !wbs.wbs_we_i) ? rdata : '0;
    end

  always_ff @(posedge wb_clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state    <= IDLE;
      opcode   <= '0;
      data_in  <= '0;
      data_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (wr && widx == 6'd1)
        for (int b = 0; b < DATA_W/8; b++)
          if (wbs.wbs_sel_i[b]) data_in[8*b +: 8] <= wbs.wbs_dat_i[8*b +: 8];
      // EXEC reads data_in before any same-edge write lands.
      if (state == EXEC) begin
        data_out <= data_in[DATA_W-1] ? '0 : data_in;
        busy     <= 1'b0;
        done     <= 1'b1;
        state    <= IDLE;
      end
      // A CTRL write overrides the completion status of a finishing op.
      if (ctrl_wr) begin
        opcode <= wbs.wbs_dat_i[3:0];
        done   <= 1'b0;
        if (state == IDLE && wbs.wbs_dat_i[3:0] == RELU_OP) begin
          state <= EXEC;
          busy  <= 1'b1;
          err   <= 1'b0;
        end else if (state == IDLE) begin
          err   <= 1'b1;
        end else begin
          err   <= wbs.wbs_dat_i[3:0] != RELU_OP;
        end
      end
    end
endmodule

// File: tb/tb_kws_relu_wb_slave.sv
// Scoreboarded bench for the ReLU Wishbone slave.
module tb_kws_relu_wb_slave;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  kws_relu_wb_slave_if bus();
  kws_relu_wb_slave dut (.wb_clk_i(clk), .wb_rst_n(rst_n), .wbs(bus));

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic [31:0] m_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output logic [31:0] rd, output bit acked);
    rd = '0;
    acked = 1'b0;
    @(negedge clk);
    bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1; bus.wbs_we_i = we;
    bus.wbs_adr_i = adr;  bus.wbs_dat_i = dat;  bus.wbs_sel_i = sel;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.wbs_ack_o) begin acked = 1'b1; rd = bus.wbs_dat_o; break; end
    end
    bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] d;
    bit ok;
    xfer(1'b1, BASE + off, dat, sel, d, ok);
    chk("wr_ack", {31'd0, ok}, 32'd1);
  endtask

  task automatic rd(input string tag, input logic [31:0] off, input logic [31:0] exp);
    logic [31:0] d, e;
    string t;
    bit ok;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    xfer(1'b0, BASE + off, 32'd0, 4'h0, d, ok);
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    if (ok) chk(t, d, e);
    else    chk({t, "_noack"}, 32'd0, 32'd1);
  endtask

  task automatic relu_run(input logic [31:0] v);
    wr(32'h04, v, 4'hF);
    wr(32'h00, 32'd5, 4'hF);
    repeat (4) @(posedge clk);
    m_out = v[31] ? 32'd0 : v;
    rd("relu_out", 32'h08, m_out);
    rd("relu_st", 32'h0C, 32'h2);
  endtask

  // Hold stb for 8 cycles; returns ack count, back-to-back acks, and idle-data violations.
  task automatic hold_stb(input logic [31:0] adr, output int cnt, output int b2b, output int dirt);
    logic prev;
    cnt = 0; b2b = 0; dirt = 0; prev = 1'b0;
    @(negedge clk);
    bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1; bus.wbs_we_i = 1'b0; bus.wbs_adr_i = adr;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.wbs_ack_o) begin
        cnt++;
        if (prev) b2b++;
        if (bus.wbs_dat_o !== m_out) dirt++;
      end else if (bus.wbs_dat_o !== 32'd0) dirt++;
      prev = bus.wbs_ack_o;
    end
    bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0;
  endtask

  initial begin
    int ops[5];
    int cnt, b2b, dirt;
    logic [31:0] d;
    bit ok;
    ops = '{-5, -1, 0, 1, 5};
    bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = 4'h0; bus.wbs_dat_i = '0;   bus.wbs_adr_i = '0;
    m_out = '0;

    #100;
    chk("rst_ack", {31'd0, bus.wbs_ack_o}, 32'd0);
    chk("rst_dat", bus.wbs_dat_o, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    rd("rst_ctrl", 32'h00, 32'd0);
    rd("rst_din",  32'h04, 32'd0);
    rd("rst_dout", 32'h08, 32'd0);
    rd("rst_st",   32'h0C, 32'd0);

    foreach (ops[i]) relu_run(ops[i]);
    relu_run(32'h8000_0000);
    relu_run(32'h7FFF_FFFF);

    wr(32'h00, 32'd3, 4'hF);
    repeat (4) @(posedge clk);
    rd("bad_st",   32'h0C, 32'h4);
    rd("bad_dout", 32'h08, m_out);
    rd("bad_ctrl", 32'h00, 32'd3);

    wr(32'h04, 32'h1122_3344, 4'hF);
    wr(32'h04, 32'hAABB_CCDD, 4'b0101);
    rd("sel_din", 32'h04, 32'h11BB_33DD);

    wr(32'h08, 32'h1234_5678, 4'hF);
    rd("ro_dout", 32'h08, m_out);
    wr(32'h10, 32'hDEAD_BEEF, 4'hF);
    rd("hole", 32'h10, 32'd0);

    hold_stb(BASE + 32'h08, cnt, b2b, dirt);
    chk("hs_cnt",  cnt,  32'd4);
    chk("hs_b2b",  b2b,  32'd0);
    chk("hs_data", dirt, 32'd0);
    hold_stb(BASE + 32'h100, cnt, b2b, dirt);
    chk("oow_cnt", cnt, 32'd0);

    wr(32'h04, 32'd7, 4'hF);
    xfer(1'b1, BASE, 32'd5, 4'hF, d, ok);
    chk("exec_ack", {31'd0, ok}, 32'd1);
    rst_n = 1'b0;
    #20;
    chk("mid_rst_ack", {31'd0, bus.wbs_ack_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    m_out = '0;
    rd("abort_dout", 32'h08, 32'd0);
    rd("abort_st",   32'h0C, 32'd0);
    rd("abort_din",  32'h04, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
